pwm_config_readback: RTL and testbench

Streams the current PWM duty configuration back to the AVR over the serial TX user interface of the AVR interface block. On a start pulse it reads NUM_CH duty bytes from the configuration memory through a read port and emits one frame: header, data bytes, checksum. The transmit side uses tx_data, new_tx_data and tx_busy. It sits beside the RX-side config writer and the PWM generator on the internal clock domain.

---
 rtl/pwm_config_readback_pkg.sv | 20 ++
 rtl/pwm_config_readback_if.sv | 23 ++
 rtl/pwm_config_readback.sv | 121 ++++++++++++
 tb/tb_pwm_config_readback.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_config_readback_pkg.sv
// Shared types and constants for the PWM configuration readback path.
// DEFAULT_HEADER is also used by the RX-side config parser to recognise frames.
package pwm_config_readback_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        GAP,
        FETCH,
        CAPTURE
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // All frame bytes, checksum included, sum to zero modulo 256.
    function automatic logic [7:0] calcChk(input logic [7:0] runningSum);
        return 8'h00 - runningSum;
    endfunction

endpackage

// File: rtl/pwm_config_readback_if.sv
// Start/status, config memory read port and AVR serial TX user port of the readback block.
interface pwm_config_readback_if #(
    parameter int AW = 4
);
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    tx_data;
    logic          new_tx_data;
    logic          tx_busy;
    logic          busy;
    logic          done;

    modport slave (
        input  start, rd_data, tx_busy,
        output rd_addr, tx_data, new_tx_data, busy, done
    );

    modport master (
        output start, rd_data, tx_busy,
        input  rd_addr, tx_data, new_tx_data, busy, done
    );
endinterface

// File: rtl/pwm_config_readback.sv
// Sends HEADER, NUM_CH duty bytes read from config memory, then a checksum over the AVR TX port.
// Every output is registered; the FSM is a state register plus a next-value comb process.
module pwm_config_readback
    import pwm_config_readback_pkg::*;
#(
    parameter int          NUM_CH = 10,
    parameter int          AW     = 4,
    parameter logic [7:0]  HEADER = DEFAULT_HEADER
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_config_readback_if.slave bus
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CH);

    state_t        r_state,   w_nextState;
    logic [7:0]    r_byte,    w_nextByte;
    logic [7:0]    r_sum,     w_nextSum;
    logic [3:0]    r_idx,     w_nextIdx;
    logic          r_isChk,   w_nextIsChk;
    logic [AW-1:0] r_rdAddr,  w_nextRdAddr;
    logic [7:0]    r_txData,  w_nextTxData;
    logic          r_newTx,   w_nextNewTx;
    logic          r_busy,    w_nextBusy;
    logic          r_done,    w_nextDone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_byte   <= 8'h00;
            r_sum    <= 8'h00;
            r_idx    <= 4'd0;
            r_isChk  <= 1'b0;
            r_rdAddr <= '0;
            r_txData <= 8'h00;
            r_newTx  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_byte   <= w_nextByte;
            r_sum    <= w_nextSum;
            r_idx    <= w_nextIdx;
            r_isChk  <= w_nextIsChk;
            r_rdAddr <= w_nextRdAddr;
            r_txData <= w_nextTxData;
            r_newTx  <= w_nextNewTx;
            r_busy   <= w_nextBusy;
            r_done   <= w_nextDone;
        end
    end

    // A start arriving in the done cycle is dropped: busy has already fallen there.
    always_comb begin
        w_nextState  = r_state;
        w_nextByte   = r_byte;
        w_nextSum    = r_sum;
        w_nextIdx    = r_idx;
        w_nextIsChk  = r_isChk;
        w_nextRdAddr = r_rdAddr;
        w_nextTxData = r_txData;
        w_nextNewTx  = 1'b0;
        w_nextBusy   = r_busy;
        w_nextDone   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start && !r_done) begin
                    w_nextByte  = HEADER;
                    w_nextSum   = HEADER;
                    w_nextIdx   = 4'd0;
                    w_nextIsChk = 1'b0;
                    w_nextBusy  = 1'b1;
                    w_nextState = SEND;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    w_nextTxData = r_byte;
                    w_nextNewTx  = 1'b1;
                    w_nextState  = GAP;
                end
            end
            GAP: begin
                if (r_isChk) begin
                    w_nextDone  = 1'b1;
                    w_nextBusy  = 1'b0;
                    w_nextIsChk = 1'b0;
                    w_nextState = IDLE;
                end else if (r_idx < LAST_IDX) begin
                    w_nextRdAddr = AW'(r_idx);
                    w_nextState  = FETCH;
                end else begin
                    w_nextByte  = calcChk(r_sum);
                    w_nextIsChk = 1'b1;
                    w_nextState = SEND;
                end
            end
            FETCH: begin
                w_nextState = CAPTURE;
            end
            CAPTURE: begin
                w_nextByte  = bus.rd_data;
                w_nextSum   = r_sum + bus.rd_data;
                w_nextIdx   = r_idx + 4'd1;
                w_nextState = SEND;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign bus.rd_addr     = r_rdAddr;
    assign bus.tx_data     = r_txData;
    assign bus.new_tx_data = r_newTx;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_pwm_config_readback.sv
// Scoreboard bench for pwm_config_readback: stimulus queues expected frame bytes,
// a negedge monitor pops and compares on every new_tx_data strobe and checks done timing.
module tb_pwm_config_readback;

    typedef struct {
        logic [7:0] data;
        bit         isHeader;
        bit         isLast;
        int         gap;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [7:0] mem [0:15];
    exp_t expQ [$];

    int  testsRun;
    int  testsFailed;
    int  cycleCnt;
    int  strobeCount;
    int  doneCount;
    int  lastStrobeCycle;
    int  headerCycle;
    int  startCycle;
    bit  expectDone;
    bit  prevStrobe;
    bit  busyModelOn;
    int  busyCnt;

    pwm_config_readback_if #(.AW(4)) bus ();

    pwm_config_readback #(
        .NUM_CH (10),
        .AW     (4),
        .HEADER (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Synchronous config memory: data appears the cycle after the address.
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    // Transmitter model: busy for 50 cycles starting the cycle after each strobe.
    always @(posedge clk) begin
        if (!busyModelOn)
            busyCnt <= 0;
        else if (bus.new_tx_data)
            busyCnt <= 50;
        else if (busyCnt != 0)
            busyCnt <= busyCnt - 1;
    end
    assign bus.tx_busy = (busyCnt != 0);

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushFrame(input logic [7:0] d [10], input logic [7:0] chk, input bit checkGaps);
        expQ.push_back('{data: 8'hA5, isHeader: 1'b1, isLast: 1'b0, gap: 0});
        for (int i = 0; i < 10; i++)
            expQ.push_back('{data: d[i], isHeader: 1'b0, isLast: 1'b0, gap: checkGaps ? 4 : 0});
        expQ.push_back('{data: chk, isHeader: 1'b0, isLast: 1'b1, gap: checkGaps ? 2 : 0});
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        bus.start  = 1'b1;
        startCycle = cycleCnt;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (doneCount < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, doneCount, target);
    endtask

    task automatic waitStrobes(input int target, input int budget);
        int n;
        n = 0;
        while (strobeCount < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("strobeWaitTimeout", int'(strobeCount >= target), 1);
    endtask

    // Monitor: compares each strobe against the scoreboard and checks strobe/done rules.
    always @(negedge clk) begin
        if (rst_n) begin
            if (expectDone) begin
                checkOutput("donePulse", int'(bus.done), 1);
                expectDone = 1'b0;
            end else if (bus.done) begin
                checkOutput("unexpectedDone", int'(bus.done), 0);
            end
            if (bus.done) doneCount++;

            if (bus.new_tx_data) begin
                exp_t e;
                strobeCount++;
                checkOutput("backToBackStrobe", int'(prevStrobe), 0);
                checkOutput("strobeWhileTxBusy", int'(bus.tx_busy), 0);
                checkOutput("busyDuringFrame", int'(bus.busy), 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedStrobe", int'(bus.tx_data), -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("txData", int'(bus.tx_data), int'(e.data));
                    if (e.gap != 0)
                        checkOutput("strobeSpacing", cycleCnt - lastStrobeCycle, e.gap);
                    if (e.isHeader) headerCycle = cycleCnt;
                    if (e.isLast) expectDone = 1'b1;
                end
                lastStrobeCycle = cycleCnt;
            end
            prevStrobe = bus.new_tx_data;
        end else begin
            prevStrobe = 1'b0;
        end
    end

    initial begin
        logic [7:0] ramp  [10];
        logic [7:0] zeros [10];
        logic [7:0] ones  [10];
        logic [7:0] mod9  [10];
        int saved;
        int n;

        testsRun = 0; testsFailed = 0; cycleCnt = 0; strobeCount = 0; doneCount = 0;
        lastStrobeCycle = 0; headerCycle = 0; startCycle = 0;
        expectDone = 1'b0; prevStrobe = 1'b0; busyModelOn = 1'b0; busyCnt = 0;
        for (int i = 0; i < 10; i++) begin
            ramp[i]  = 8'(i + 1);
            zeros[i] = 8'h00;
            ones[i]  = 8'hFF;
            mod9[i]  = 8'(i + 1);
        end
        mod9[9] = 8'h80;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        rst_n = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetRdAddr", int'(bus.rd_addr), 0);
        checkOutput("resetTxData", int'(bus.tx_data), 0);
        checkOutput("resetNewTx", int'(bus.new_tx_data), 0);
        checkOutput("resetBusy", int'(bus.busy), 0);
        checkOutput("resetDone", int'(bus.done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] ramp frame, tx idle");
        for (int i = 0; i < 10; i++) mem[i] = ramp[i];
        pushFrame(ramp, 8'h24, 1'b1);
        applyStimulus();
        waitDone(1, 200, "frameRamp");
        checkOutput("startLatency", headerCycle - startCycle, 2);
        checkOutput("busyAfterDone", int'(bus.busy), 0);

        $display("[TB] all-zero and all-FF frames");
        for (int i = 0; i < 10; i++) mem[i] = zeros[i];
        pushFrame(zeros, 8'h5B, 1'b1);
        applyStimulus();
        waitDone(2, 200, "frameZeros");
        for (int i = 0; i < 10; i++) mem[i] = ones[i];
        pushFrame(ones, 8'h65, 1'b1);
        applyStimulus();
        waitDone(3, 200, "frameOnes");

        $display("[TB] ramp frame with 50-cycle transmitter busy");
        for (int i = 0; i < 10; i++) mem[i] = ramp[i];
        busyModelOn = 1'b1;
        pushFrame(ramp, 8'h24, 1'b0);
        applyStimulus();
        waitDone(4, 2000, "frameTxBusy");
        busyModelOn = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] start mid-frame and in the done cycle");
        pushFrame(ramp, 8'h24, 1'b1);
        saved = strobeCount;
        applyStimulus();
        waitStrobes(saved + 3, 100);
        applyStimulus();
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneSeenForRetrigger", int'(bus.done), 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("doneCycleStartDropped", int'(bus.busy), 0);
        checkOutput("frameStrobeCount", strobeCount - saved, 12);

        $display("[TB] start one cycle after done");
        pushFrame(ramp, 8'h24, 1'b1);
        pushFrame(ramp, 8'h24, 1'b1);
        saved = doneCount;
        applyStimulus();
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(saved + 2, 200, "backToBackFrames");

        $display("[TB] reset during byte 5");
        pushFrame(ramp, 8'h24, 1'b1);
        saved = strobeCount;
        applyStimulus();
        waitStrobes(saved + 5, 100);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midResetNewTx", int'(bus.new_tx_data), 0);
        checkOutput("midResetBusy", int'(bus.busy), 0);
        checkOutput("midResetTxData", int'(bus.tx_data), 0);
        checkOutput("midResetRdAddr", int'(bus.rd_addr), 0);
        expQ.delete();
        expectDone = 1'b0;
        saved = doneCount;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("noDoneAfterReset", doneCount, saved);
        checkOutput("idleAfterReset", int'(bus.busy), 0);
        pushFrame(ramp, 8'h24, 1'b1);
        applyStimulus();
        waitDone(saved + 1, 200, "frameAfterReset");

        $display("[TB] memory write while frame in flight");
        pushFrame(mod9, 8'hAE, 1'b1);
        saved = strobeCount;
        applyStimulus();
        waitStrobes(saved + 3, 100);
        mem[9] = 8'h80;
        waitDone(doneCount + 1, 200, "frameLiveWrite");

        repeat (5) @(negedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
